// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit with HI/LO registers.
//   Operations: MULT, MULTU, DIV, DIVU (op_i 00/01/10/11), plus MTHI/MTLO.
//   Each operation takes 33 cycles from the start edge until HI/LO are written.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   start_i, op_i        launch the operation (sampled only in IDLE)
//   rsData_i, rtData_i   operand A (multiplicand/dividend, MTHI/MTLO source), operand B
//   mthi_i, mtlo_i       write rsData_i to HI / LO (IDLE only, start_i low)
//   busy_o, done_o       in-flight indicator, one-cycle completion pulse
//   hi_o, lo_o           HI (product high / remainder), LO (product low / quotient)
module mult_div_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] rsData_i,
    input  logic [31:0] rtData_i,
    input  logic        mthi_i,
    input  logic        mtlo_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic        sa_q, sa_d, sb_q, sb_d;
    logic [31:0] a_q, a_d;        // |A|: multiplicand / dividend magnitude
    logic [31:0] b_q, b_d;        // |B|: multiplier / divisor magnitude
    logic [31:0] rs_raw_q, rs_raw_d;
    logic [63:0] acc_q, acc_d;    // mult: {partial product, multiplier}; div: low half = dividend/quotient
    logic [31:0] rem_q, rem_d;    // divide partial remainder (always < divisor)
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d;

    // op_i[0] set means unsigned
    logic        sgn_in;
    logic [31:0] a_mag, b_mag;
    assign sgn_in = ~op_i[0];
    assign a_mag  = (sgn_in && rsData_i[31]) ? -rsData_i : rsData_i;
    assign b_mag  = (sgn_in && rtData_i[31]) ? -rtData_i : rtData_i;

    // Multiply step: add multiplicand into the top half when multiplier LSB is set, then shift right.
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);

    // Restoring divide step: 33-bit shifted remainder, trial subtract of the divisor.
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic        qbit;
    assign div_shift = {rem_q, acc_q[31]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, b_q};
    assign qbit      = ~div_diff[33];

    logic [63:0] prod_neg;
    logic [31:0] quo_neg, rem_neg;
    assign prod_neg = -acc_q;
    assign quo_neg  = -acc_q[31:0];
    assign rem_neg  = -rem_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        a_d      = a_q;
        b_d      = b_q;
        rs_raw_d = rs_raw_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d     = op_i;
                    sa_d     = sgn_in & rsData_i[31];
                    sb_d     = sgn_in & rtData_i[31];
                    a_d      = a_mag;
                    b_d      = b_mag;
                    rs_raw_d = rsData_i;
                    cnt_d    = 6'd0;
                    rem_d    = 32'd0;
                    acc_d    = op_i[1] ? {32'd0, a_mag} : {32'd0, b_mag};
                    state_d  = S_RUN;
                end else begin
                    if (mthi_i) hi_d = rsData_i;
                    if (mtlo_i) lo_d = rsData_i;
                end
            end
            S_RUN: begin
                if (op_q[1]) begin
                    rem_d = qbit ? div_diff[31:0] : div_shift[31:0];
                    acc_d = {acc_q[63:32], acc_q[30:0], qbit};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = S_FIX;
            end
            S_FIX: begin
                if (!op_q[1]) begin
                    {hi_d, lo_d} = (sa_q ^ sb_q) ? prod_neg : acc_q;
                end else if (b_q == 32'd0) begin
                    // Divide by zero: architectural result, no sign fix.
                    lo_d = 32'hFFFF_FFFF;
                    hi_d = rs_raw_q;
                end else begin
                    lo_d = (sa_q ^ sb_q) ? quo_neg : acc_q[31:0];
                    hi_d = sa_q ? rem_neg : rem_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            op_q     <= 2'd0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            rs_raw_q <= 32'd0;
            acc_q    <= 64'd0;
            rem_q    <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rs_raw_q <= rs_raw_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] rs = 32'd0, rt = 32'd0;
    logic        mthi = 1'b0, mtlo = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    mult_div_unit dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
        .rsData_i(rs), .rtData_i(rt), .mthi_i(mthi), .mtlo_i(mtlo),
        .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];
    logic [31:0] hi_before, lo_before;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Scoreboard: every done pulse pops one expected {HI,LO}.
    always @(negedge clk) begin
        if (!rst) begin
            check("busy_and_done", {31'd0, busy & done}, 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check("hi", hi, e[63:32]);
                    check("lo", lo, e[31:0]);
                end
            end
        end
    end

    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] e, input bit push, input bit with_mthi);
        @(negedge clk);
        hi_before = hi;
        lo_before = lo;
        op = o; rs = a; rt = b; start = 1'b1; mthi = with_mthi;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0; mthi = 1'b0;
    endtask

    // Called 1 time unit after the start edge; expects done after exactly 33 more edges.
    task automatic wait_done(input bit glitch);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 16) begin
                check("busy_mid", {31'd0, busy}, 32'd1);
                check("hi_hold", hi, hi_before);
                check("lo_hold", lo, lo_before);
            end
            if (glitch && n == 5) begin
                @(negedge clk);
                start = 1'b1; mtlo = 1'b1; op = 2'd3; rs = 32'hDEAD_BEEF; rt = 32'd9;
                @(posedge clk);
                #1;
                n++;
                start = 1'b0; mtlo = 1'b0;
            end
        end
        check("latency", n, 33);
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{2'd3, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
        vecs[5]  = '{2'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6]  = '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[7]  = '{2'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[8]  = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[9]  = '{2'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3};
        vecs[10] = '{2'd1, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0};
        vecs[11] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
        vecs[12] = '{2'd3, 32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999};
        vecs[13] = '{2'd0, 32'd0,         32'h1234_5678, 32'd0,         32'd0};
        vecs[14] = '{2'd3, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};

        // Reset state
        #2;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven, back-to-back operations
        for (int i = 0; i < 15; i++) begin
            start_op(vecs[i].op, vecs[i].rs, vecs[i].rt, {vecs[i].ehi, vecs[i].elo}, 1'b1, 1'b0);
            wait_done(1'b0);
        end

        // MTHI in IDLE: single-cycle write, LO untouched, no busy/done
        @(negedge clk);
        lo_before = lo;
        rs = 32'hA5A5_A5A5; mthi = 1'b1;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        check("mthi_hi", hi, 32'hA5A5_A5A5);
        check("mthi_lo", lo, lo_before);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_done", {31'd0, done}, 32'd0);

        // MTLO alone
        @(negedge clk);
        rs = 32'h0BAD_F00D; mtlo = 1'b1;
        @(posedge clk);
        #1;
        mtlo = 1'b0;
        check("mtlo_lo", lo, 32'h0BAD_F00D);
        check("mtlo_hi", hi, 32'hA5A5_A5A5);

        // MULT 2x3 with mthi alongside start (dropped), then start/mtlo mid-RUN (ignored)
        start_op(2'd0, 32'd2, 32'd3, {32'd0, 32'd6}, 1'b1, 1'b1);
        wait_done(1'b1);

        // Reset mid-operation discards the op, outputs clear immediately
        start_op(2'd3, 32'd100, 32'd7, 64'd0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start_op(2'd3, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1, 1'b0);
        wait_done(1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits directly downstream of the register file and consumes the `rsData`/`rtData` operands that the register file produces. Results are read back through `hi`/`lo` for MFHI/MFLO. A start/busy/done handshake lets the control unit stall issue while an operation is in flight.

## Interface
- No parameters; the datapath is fixed at 32 bits (64-bit product).
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  launches the operation selected by `op`; sampled only in IDLE
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `rsData`  in  32  operand A (multiplicand / dividend; MTHI/MTLO source)
- `rtData`  in  32  operand B (multiplier / divisor)
- `mthi`  in  1  write `rsData` to HI
- `mtlo`  in  1  write `rsData` to LO
- `busy`  out  1  high while an operation is in flight
- `done`  out  1  one-cycle pulse when HI/LO receive a result
- `hi`  out  32  HI register (product[63:32] / remainder)
- `lo`  out  32  LO register (product[31:0] / quotient)

## Operation
- States:
  - IDLE → RUN on `start`.
  - RUN runs 32 iterations, then → FIX.
  - FIX → IDLE after one cycle.
- At the start edge: latch `op`, sign flags, and the operand magnitudes (|x| for signed ops, raw value for unsigned ops). Clear the 6-bit iteration counter.
- Operands are captured only at the start edge. Input changes during RUN/FIX are ignored.
- Multiply: shift-add on magnitudes, 1 bit per cycle, into a 64-bit accumulator. In FIX, negate the 64-bit result (two's complement) if the op is signed and the operand signs differ.
- Divide: restoring division on magnitudes, 1 quotient bit per cycle, with a 33-bit partial remainder.
  - In FIX for signed ops, negate the quotient if the signs differ and negate the remainder if the dividend is negative.
  - LO = quotient, HI = remainder.
- Divide by zero (DIV or DIVU): LO = 0xFFFFFFFF, HI = original `rsData` unmodified. No sign fix is applied, and latency is unchanged.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This falls out of the magnitude path and needs no special case.
- HI/LO are written only in FIX, or by MTHI/MTLO.
- MTHI/MTLO:
  - Honoured only in IDLE with `start` low; the write takes effect at the next edge.
  - `mthi` and `mtlo` both high writes HI and LO together.
  - Dropped while busy.
  - Dropped when asserted together with `start` (start has priority).
- `start` while busy is ignored and is not queued.
- Reset (asynchronous, any state, including mid-operation):
  - Immediately: state = IDLE, `hi` = `lo` = 0, `busy` = 0, `done` = 0, counter = 0.
  - An in-flight operation is discarded.

## Timing
- Edge 0: `start` sampled high in IDLE. `busy` = 1 after edge 0.
- Edges 1–32: RUN iterations. State = FIX after edge 32.
- Edge 33: HI/LO updated, `done` = 1 for exactly the following cycle, `busy` = 0, state = IDLE.
- Result latency: 33 cycles from the start edge to HI/LO valid.
- `done` and `busy` are never high in the same cycle.
- A new `start` may be asserted in the cycle `done` is high; it is accepted at the next edge, giving back-to-back operations every 34 cycles.
- `hi`/`lo` are registered outputs and hold their previous values for the whole of RUN and FIX.
- MTHI/MTLO: single-cycle write, with no `busy` or `done` activity.

## Test plan
- MULT rs=0xFFFFFFFD (−3), rt=7, start at edge 0 → HI=0xFFFFFFFF, LO=0xFFFFFFEB after edge 33; `done` high for 1 cycle; `busy` high during cycles 1–33.
- MULTU rs=rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU rs=0x00001234, rt=0 → LO=0xFFFFFFFF, HI=0x00001234 at edge 33. Repeat with DIV rs=0xFFFFFFF9, rt=0 → LO=0xFFFFFFFF, HI=0xFFFFFFF9 (no sign fix).
- MTHI rs=0xA5A5A5A5 in IDLE → HI=0xA5A5A5A5 next edge, LO unchanged. Then start MULT 2×3 and pulse `start`/`mtlo` with new operands mid-RUN → both ignored; HI=0, LO=6 at edge 33.
- Start DIVU 100/7, assert `rst` asynchronously mid-cycle 10 → `busy`, `done`, `hi`, `lo` = 0 immediately. After release, DIVU 100/7 completes with LO=14, HI=2 exactly 33 edges after the new start.
